gauss_row_fetch_ctrl: RTL and testbench

- Row-fetch sequencer that sits directly upstream of the 10-row line buffer.
- Issues image-SRAM row reads and drives the buffer's mode, write-enable and zero-fill controls so that rows enter `buffer_data_0` back-to-back, with zero padding at the top and bottom of the image.
- Tells the downstream blur/detect datapath, via `win_valid`/`win_row`, when the line buffer holds a complete vertical window.
- Supports two passes: Gaussian (zero-padded, shifts every cycle) and detect-filter (write-enable-gated shift).

---
 rtl/gauss_row_fetch_ctrl_if.sv | 29 ++
 rtl/gauss_row_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_gauss_row_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gauss_row_fetch_ctrl_if.sv
// Signal bundle between the row-fetch sequencer, the image SRAM read port,
// the 10-row line buffer controls and the downstream window consumer.
interface gauss_row_fetch_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              pass_sel;
    logic              img_re;
    logic [ADDR_W-1:0] img_addr;
    logic [2:0]        buffer_mode;
    logic              buffer_we;
    logic              fill_zero;
    logic              win_valid;
    logic [ADDR_W-1:0] win_row;
    logic              busy;
    logic              done;

    modport master (
        input  start, pass_sel,
        output img_re, img_addr, buffer_mode, buffer_we, fill_zero,
               win_valid, win_row, busy, done
    );

    modport slave (
        output start, pass_sel,
        input  img_re, img_addr, buffer_mode, buffer_we, fill_zero,
               win_valid, win_row, busy, done
    );
endinterface

// File: rtl/gauss_row_fetch_ctrl.sv
// Row-fetch sequencer feeding the line buffer for the Gaussian and detect passes.
// Optional pass-length counter output enabled by GAUSS_ROW_FETCH_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start, buffer_mode 0
// RUN   | reads, head loads and window strobes in progress
// FIN   | one-cycle done pulse
module gauss_row_fetch_ctrl #(
    parameter int IMG_ROWS = 480,
    parameter int HALO     = 2,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 9
) (
    input  logic clk,
    input  logic rst_n,
`ifdef GAUSS_ROW_FETCH_PERF_EN
    output logic [15:0] pass_cycles,
`endif
    gauss_row_fetch_ctrl_if.master bus
);
    localparam int G_LEN_I = RD_LAT + IMG_ROWS + 2*HALO;
    localparam int D_LEN_I = RD_LAT + IMG_ROWS;
    localparam int CNT_W   = $clog2(G_LEN_I + 1) + 1;

    localparam logic [CNT_W-1:0] G_LEN      = CNT_W'(G_LEN_I);
    localparam logic [CNT_W-1:0] D_LEN      = CNT_W'(D_LEN_I);
    localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] G_RD_FIRST = CNT_W'(HALO);
    localparam logic [CNT_W-1:0] G_RD_LAST  = CNT_W'(HALO + IMG_ROWS - 1);
    localparam logic [CNT_W-1:0] D_RD_LAST  = CNT_W'(IMG_ROWS - 1);
    localparam logic [CNT_W-1:0] G_WE_FIRST = CNT_W'(RD_LAT + HALO);
    localparam logic [CNT_W-1:0] G_WE_LAST  = CNT_W'(RD_LAT + HALO + IMG_ROWS - 1);
    localparam logic [CNT_W-1:0] G_WIN_1ST  = CNT_W'(RD_LAT + 2*HALO + 1);
    localparam logic [CNT_W-1:0] D_WIN_1ST  = CNT_W'(RD_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic             pass_det;
    logic [CNT_W-1:0] run_left;
    logic [CNT_W-1:0] run_len, rd_first, rd_last, win_first, t;

    assign run_len   = pass_det ? D_LEN : G_LEN;
    assign rd_first  = pass_det ? '0 : G_RD_FIRST;
    assign rd_last   = pass_det ? D_RD_LAST : G_RD_LAST;
    assign win_first = pass_det ? D_WIN_1ST : G_WIN_1ST;

    // run_left is the pass timer: loaded with the RUN length, terminal count 0 ends RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pass_det <= 1'b0;
            run_left <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                pass_det <= bus.pass_sel;
                run_left <= bus.pass_sel ? D_LEN : G_LEN;
            end else if (state == RUN && run_left != '0) begin
                run_left <= run_left - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        t               = run_len - run_left;
        bus.img_re      = 1'b0;
        bus.img_addr    = '0;
        bus.buffer_mode = 3'd0;
        bus.buffer_we   = 1'b0;
        bus.fill_zero   = 1'b0;
        bus.win_valid   = 1'b0;
        bus.win_row     = '0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                bus.busy        = 1'b1;
                bus.buffer_mode = pass_det ? 3'd2 : 3'd1;
                if (t >= rd_first && t <= rd_last) begin
                    bus.img_re   = 1'b1;
                    bus.img_addr = ADDR_W'(t - rd_first);
                end
                // head-load slots start RD_LAT cycles in and end with the timer
                if (t >= LAT_C && t < run_len) begin
                    if (pass_det || (t >= G_WE_FIRST && t <= G_WE_LAST))
                        bus.buffer_we = 1'b1;
                    else
                        bus.fill_zero = 1'b1;
                end
                if (t >= win_first) begin
                    bus.win_valid = 1'b1;
                    bus.win_row   = ADDR_W'(t - win_first);
                end
                if (run_left == '0) state_nxt = FIN;
            end
            FIN: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GAUSS_ROW_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            pass_cycles <= 16'd0;
        else if (state == IDLE && bus.start)
            pass_cycles <= 16'd0;
        else if (state == RUN)
            pass_cycles <= pass_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_gauss_row_fetch_ctrl.sv
// Scoreboard bench: two sequencer instances (RD_LAT 1 and 2) share one stimulus stream;
// expected events come from the row/slot/window formulas and are popped by a monitor.
module tb_gauss_row_fetch_ctrl;
    localparam int ROWS = 8;
    localparam int HALO = 2;
    localparam int AW   = 9;
    localparam int NK   = 5;   // event kinds: 0 read, 1 we, 2 fill_zero, 3 window, 4 done

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_r = 1'b0;
    logic psel_r = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    ev_t q[2][NK][$];
    int  run_lo[2], run_hi[2], fin_cyc[2], pass_m[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gauss_row_fetch_ctrl_if #(.ADDR_W(AW)) bus_g ();
    gauss_row_fetch_ctrl_if #(.ADDR_W(AW)) bus_d ();
    assign bus_g.start    = start_r;
    assign bus_g.pass_sel = psel_r;
    assign bus_d.start    = start_r;
    assign bus_d.pass_sel = psel_r;

`ifdef GAUSS_ROW_FETCH_PERF_EN
    logic [15:0] pc_g, pc_d;
`endif

    gauss_row_fetch_ctrl #(.IMG_ROWS(ROWS), .HALO(HALO), .RD_LAT(1), .ADDR_W(AW)) dut_g (
        .clk(clk),
        .rst_n(rst_n),
`ifdef GAUSS_ROW_FETCH_PERF_EN
        .pass_cycles(pc_g),
`endif
        .bus(bus_g.master)
    );

    gauss_row_fetch_ctrl #(.IMG_ROWS(ROWS), .HALO(HALO), .RD_LAT(2), .ADDR_W(AW)) dut_d (
        .clk(clk),
        .rst_n(rst_n),
`ifdef GAUSS_ROW_FETCH_PERF_EN
        .pass_cycles(pc_d),
`endif
        .bus(bus_d.master)
    );

    logic [1:0]    m_re, m_we, m_fz, m_wv, m_done, m_busy;
    logic [AW-1:0] m_addr[2], m_row[2];
    logic [2:0]    m_mode[2];
    assign m_re   = {bus_d.img_re,    bus_g.img_re};
    assign m_we   = {bus_d.buffer_we, bus_g.buffer_we};
    assign m_fz   = {bus_d.fill_zero, bus_g.fill_zero};
    assign m_wv   = {bus_d.win_valid, bus_g.win_valid};
    assign m_done = {bus_d.done,      bus_g.done};
    assign m_busy = {bus_d.busy,      bus_g.busy};
    assign m_addr[0] = bus_g.img_addr;
    assign m_addr[1] = bus_d.img_addr;
    assign m_row[0]  = bus_g.win_row;
    assign m_row[1]  = bus_d.win_row;
    assign m_mode[0] = bus_g.buffer_mode;
    assign m_mode[1] = bus_d.buffer_mode;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chk_ev(input string name, input int inst, input int k, input bit act, input int aval);
        bit  expf;
        ev_t e;
        expf = (q[inst][k].size() > 0) && (q[inst][k][0].cyc == cyc);
        chk(name, inst, int'(act), int'(expf));
        if (expf) begin
            e = q[inst][k].pop_front();
            if (act) chk({name, "_value"}, inst, aval, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                bit bz;
                bz = (cyc >= run_lo[i]) && (cyc <= run_hi[i]);
                chk("busy", i, int'(m_busy[i]), int'(bz));
                chk("buffer_mode", i, int'(m_mode[i]), bz ? (pass_m[i] != 0 ? 2 : 1) : 0);
                chk_ev("img_re", i, 0, m_re[i], int'(m_addr[i]));
                chk_ev("buffer_we", i, 1, m_we[i], 0);
                chk_ev("fill_zero", i, 2, m_fz[i], 0);
                chk_ev("win_valid", i, 3, m_wv[i], int'(m_row[i]));
`ifdef GAUSS_ROW_FETCH_PERF_EN
                if (m_done[i])
                    chk("pass_cycles", i, (i == 0) ? int'(pc_g) : int'(pc_d), run_hi[i] - run_lo[i] + 1);
`endif
                chk_ev("done", i, 4, m_done[i], 0);
            end
        end
    end

    function automatic void push(input int i, input int k, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q[i][k].push_back(e);
    endfunction

    // Expected pass built straight from the slot / read / window timing rules
    function automatic void issue(input int i, input int c0, input bit det);
        int lat, c1, w0, s_n;
        lat = (i == 0) ? 1 : 2;
        c1  = c0 + 1;
        w0  = c1 + lat;
        s_n = det ? ROWS : ROWS + 2*HALO;
        pass_m[i]  = int'(det);
        run_lo[i]  = c1;
        run_hi[i]  = w0 + s_n;
        fin_cyc[i] = w0 + s_n + 1;
        if (det) begin
            for (int r = 0; r < ROWS; r++) push(i, 0, w0 + r - lat, r);
            for (int s = 0; s < s_n; s++) push(i, 1, w0 + s, 0);
            for (int s = 1; s < s_n; s++) push(i, 3, w0 + s + 1, s - 1);
        end else begin
            for (int r = 0; r < ROWS; r++) push(i, 0, w0 + HALO + r - lat, r);
            for (int s = 0; s < s_n; s++)
                if (s < HALO || s >= HALO + ROWS) push(i, 2, w0 + s, 0);
                else                              push(i, 1, w0 + s, 0);
            for (int s = 2*HALO; s < s_n; s++) push(i, 3, w0 + s + 1, s - 2*HALO);
        end
        push(i, 4, w0 + s_n + 1, 0);
    endfunction

    function automatic void flush_model();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NK; k++) q[i][k].delete();
            run_lo[i]  = 0;
            run_hi[i]  = -1;
            fin_cyc[i] = -1;
            pass_m[i]  = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit det);
        start_r = 1'b1;
        psel_r  = det;
        for (int i = 0; i < 2; i++)
            if (cyc > fin_cyc[i]) issue(i, cyc, det);
        step();
        start_r = 1'b0;
        psel_r  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step();
        flush_model();
        repeat (n - 1) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && (cyc <= fin_cyc[0] || cyc <= fin_cyc[1]); n++) step();
        step();
    endtask

    initial begin
        flush_model();
        rst_n = 1'b0;
        step();
        flush_model();
        mon_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();

        // Gaussian pass with an ignored mid-pass start, then a clean follow-up pass
        pulse_start(1'b0);
        repeat (4) step();
        pulse_start(1'b0);
        wait_idle();
        pulse_start(1'b0);
        wait_idle();

        // Detect pass
        pulse_start(1'b1);
        wait_idle();

        // Reset at cycle 6 of a Gaussian pass aborts without done
        pulse_start(1'b0);
        repeat (5) step();
        do_reset(1);
        repeat (3) step();
        pulse_start(1'b0);
        wait_idle();

        // Randomized start / pass_sel / occasional reset
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 39));
            if (r < 4)       pulse_start(1'($urandom_range(0, 1)));
            else if (r == 4) do_reset(int'($urandom_range(1, 2)));
            else             step();
        end
        wait_idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
